// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array datapath and its writeback paths.
package systolic_pkg;

    typedef enum logic {IDLE, STREAM} drain_state_t;

    // Row index width; a single-row array still needs a one-bit index port.
    function automatic int row_w(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

    // Arithmetic right shift, then clamp into the signed dw-bit range.
    function automatic logic signed [63:0] sat_requant(input logic signed [63:0] acc,
                                                       input int unsigned shift,
                                                       input int unsigned dw);
        logic signed [63:0] shifted;
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        shifted = acc >>> shift;
        max_v   = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (dw - 1));
        if (shifted > max_v) return max_v;
        if (shifted < min_v) return min_v;
        return shifted;
    endfunction

endpackage

// File: rtl/systolic_result_drain_requant_sat.sv
// One-element requantizer: signed accumulator shifted and saturated to DATA_WIDTH.
// Only built when RESULT_REQUANT_EN is defined.
`ifdef RESULT_REQUANT_EN
module requant_sat
    import systolic_pkg::*;
#(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 8,
    parameter int SHIFT_W    = 5
) (
    input  logic signed [ACC_WIDTH-1:0]  acc,
    input  logic        [SHIFT_W-1:0]    shift,
    output logic        [DATA_WIDTH-1:0] result
);

    assign result = DATA_WIDTH'(sat_requant(64'(acc), 32'(shift), 32'(DATA_WIDTH)));

endmodule
`endif

// File: rtl/systolic_result_drain.sv
// Drain end of the systolic array: snapshot the accumulators, clear the array, stream rows.
// Define RESULT_REQUANT_EN to add the shift port and per-element shift/saturate to DATA_WIDTH.
module systolic_result_drain
    import systolic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int MATRIX_SIZE = 8,
    parameter int ACC_WIDTH   = 32,
`ifdef RESULT_REQUANT_EN
    localparam int OUT_W   = DATA_WIDTH,
    localparam int SHIFT_W = $clog2(ACC_WIDTH),
`else
    localparam int OUT_W   = ACC_WIDTH,
`endif
    localparam int ROW_W   = row_w(MATRIX_SIZE)
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         capture,
    input  logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] acc_in_flat,
`ifdef RESULT_REQUANT_EN
    input  logic [SHIFT_W-1:0]                           shift,
`endif
    output logic                                         acc_clr,
    output logic                                         busy,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [OUT_W*MATRIX_SIZE-1:0]                 out_data,
    output logic [ROW_W-1:0]                             out_row,
    output logic                                         out_last,
    output logic                                         done,
    output logic                                         overrun
);

    localparam int               ROW_BITS = ACC_WIDTH * MATRIX_SIZE;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(MATRIX_SIZE - 1);

    drain_state_t                                 state;
    drain_state_t                                 next_state;
    logic [ACC_WIDTH*MATRIX_SIZE*MATRIX_SIZE-1:0] shadow;
    logic [ROW_W-1:0]                             row_q;
    logic                                         acc_clr_q;
    logic                                         done_q;
    logic                                         overrun_q;
    logic                                         accept;
    logic                                         transfer;
    logic [ROW_BITS-1:0]                          shadow_row;
    logic [OUT_W*MATRIX_SIZE-1:0]                 row_data;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= next_state;
    end

    // out_ready only steers next-state and row advance, never an output directly.
    always_comb begin
        next_state = state;
        busy       = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        accept     = 1'b0;
        transfer   = 1'b0;
        case (state)
            IDLE: begin
                accept = capture;
                if (capture) next_state = STREAM;
            end
            STREAM: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_last  = (row_q == LAST_ROW);
                transfer  = out_ready;
                if (out_ready && out_last) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow    <= '0;
            row_q     <= '0;
            acc_clr_q <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            acc_clr_q <= accept;
            done_q    <= transfer && out_last;
            if (accept) begin
                shadow <= acc_in_flat;
                row_q  <= '0;
            end else if (transfer) begin
                row_q  <= out_last ? '0 : row_q + ROW_W'(1);
            end
            if (state == STREAM && capture) overrun_q <= 1'b1;
        end
    end

    assign acc_clr    = acc_clr_q;
    assign done       = done_q;
    assign overrun    = overrun_q;
    assign out_row    = row_q;
    assign shadow_row = shadow[int'(row_q) * ROW_BITS +: ROW_BITS];

`ifdef RESULT_REQUANT_EN
    logic [SHIFT_W-1:0] shift_q;

    // Shift amount belongs to the snapshot, so it is latched alongside it.
    always_ff @(posedge clk) begin
        if (rst)         shift_q <= '0;
        else if (accept) shift_q <= shift;
    end

    for (genvar c = 0; c < MATRIX_SIZE; c++) begin : g_requant
        requant_sat #(
            .ACC_WIDTH  (ACC_WIDTH),
            .DATA_WIDTH (DATA_WIDTH),
            .SHIFT_W    (SHIFT_W)
        ) u_requant (
            .acc    (shadow_row[c*ACC_WIDTH +: ACC_WIDTH]),
            .shift  (shift_q),
            .result (row_data[c*DATA_WIDTH +: DATA_WIDTH])
        );
    end
`else
    assign row_data = shadow_row;
`endif

    assign out_data = out_valid ? row_data : '0;

endmodule

// File: tb/tb_systolic_result_drain.sv
// Self-checking bench for systolic_result_drain (M=4); covers raw and RESULT_REQUANT_EN builds.
`timescale 1ns/1ps
module tb_systolic_result_drain;

    localparam int DW = 8;
    localparam int M  = 4;
    localparam int AW = 32;
    localparam int RW = 2;
    localparam int SW = $clog2(AW);
`ifdef RESULT_REQUANT_EN
    localparam int OW = DW;
    localparam logic [OW*M-1:0] ROW2     = {8'd35, 8'd34, 8'd33, 8'd32};
    localparam logic [OW*M-1:0] REQ_ROW0 = {8'h80, 8'h07, 8'hF0, 8'h7F};
`else
    localparam int OW = AW;
    localparam logic [OW*M-1:0] ROW2     = {32'd35, 32'd34, 32'd33, 32'd32};
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              capture;
    logic              out_ready;
    logic              acc_clr;
    logic              busy;
    logic              out_valid;
    logic              out_last;
    logic              done;
    logic              overrun;
    logic [AW*M*M-1:0] acc_in_flat;
    logic [OW*M-1:0]   out_data;
    logic [RW-1:0]     out_row;
`ifdef RESULT_REQUANT_EN
    logic [SW-1:0]     shift;
`endif

    systolic_result_drain #(
        .DATA_WIDTH  (DW),
        .MATRIX_SIZE (M),
        .ACC_WIDTH   (AW)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .capture     (capture),
        .acc_in_flat (acc_in_flat),
`ifdef RESULT_REQUANT_EN
        .shift       (shift),
`endif
        .acc_clr     (acc_clr),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_row     (out_row),
        .out_last    (out_last),
        .done        (done),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [OW*M-1:0] data;
        logic [RW-1:0]   row;
        logic            last;
    } beat_t;

    typedef struct {
        logic          cap;
        logic          rdy;
        logic          valid;
        logic [RW-1:0] row;
        logic          last;
        logic          clr;
        logic          done;
        logic          busy;
    } vec_t;

    beat_t       sb[$];
    vec_t        vecs[6];
    int          checks   = 0;
    int          failures = 0;
    int          beats    = 0;
    int          cur_shift = 0;
    logic [OW*M-1:0] held_data;

    task automatic checkVec(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    function automatic vec_t mkvec(input logic cap, input logic rdy, input logic valid, input int row,
                                   input logic last, input logic clr, input logic dn, input logic bsy);
        vec_t v;
        v.cap = cap;  v.rdy = rdy;   v.valid = valid; v.row  = RW'(row);
        v.last = last; v.clr = clr;  v.done  = dn;    v.busy = bsy;
        return v;
    endfunction

    // Reference element: raw accumulator, or asr + signed saturation when requantizing.
    function automatic logic [OW-1:0] model_elem(input logic [AW-1:0] acc, input int sh);
`ifdef RESULT_REQUANT_EN
        longint v;
        v = longint'($signed(acc)) >>> sh;
        if (v > 127)  return OW'(127);
        if (v < -128) return OW'(-128);
        return OW'(v);
`else
        if (sh != 0) return '0;
        return acc;
`endif
    endfunction

    task automatic load_tile(input int base);
        for (int r = 0; r < M; r++)
            for (int c = 0; c < M; c++)
                acc_in_flat[(r*M+c)*AW +: AW] = AW'(base + 16*r + c);
    endtask

    task automatic push_snapshot();
        for (int r = 0; r < M; r++) begin
            beat_t e;
            e.row  = RW'(r);
            e.last = (r == M-1);
            for (int c = 0; c < M; c++)
                e.data[c*OW +: OW] = model_elem(acc_in_flat[(r*M+c)*AW +: AW], cur_shift);
            sb.push_back(e);
        end
    endtask

    // Drive inputs just after a falling edge, then return at the next falling edge.
    task automatic applyStimulus(input logic cap, input logic rdy);
        capture   = cap;
        out_ready = rdy;
`ifdef RESULT_REQUANT_EN
        shift     = SW'(cur_shift);
`endif
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain_until_done(input int budget, input string name);
        int n = 0;
        while (!done && n < budget) begin
            applyStimulus(1'b0, 1'b1);
            n++;
        end
        checkOutput(name, done, 1'b1);
    endtask

    // Beat monitor: a transfer happens at the next rising edge when valid & ready & !rst.
    always @(negedge clk) begin
        #2;
        if (out_valid && out_ready && !rst) begin
            beats++;
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_beat: got row %0d, expected no beat", out_row);
            end else begin : pop
                beat_t e;
                e = sb.pop_front();
                checkVec("beat_data", 512'(out_data), 512'(e.data));
                checkVec("beat_row", 512'(out_row), 512'(e.row));
                checkOutput("beat_last", out_last, e.last);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL timeout: got no completion, expected $finish before 200us");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst = 1'b1; capture = 1'b0; out_ready = 1'b0; acc_in_flat = '0;
`ifdef RESULT_REQUANT_EN
        shift = '0;
`endif
        vecs[0] = mkvec(1, 1, 1, 0, 0, 1, 0, 1);
        vecs[1] = mkvec(0, 1, 1, 1, 0, 0, 0, 1);
        vecs[2] = mkvec(0, 1, 1, 2, 0, 0, 0, 1);
        vecs[3] = mkvec(0, 1, 1, 3, 1, 0, 0, 1);
        vecs[4] = mkvec(0, 1, 0, 0, 0, 0, 1, 0);
        vecs[5] = mkvec(0, 1, 0, 0, 0, 0, 0, 0);

        repeat (3) @(negedge clk);
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_clr", acc_clr, 1'b0);
        checkOutput("rst_done", done, 1'b0);
        checkOutput("rst_overrun", overrun, 1'b0);
        checkOutput("rst_last", out_last, 1'b0);
        checkVec("rst_row", 512'(out_row), 512'(0));
        checkVec("rst_data", 512'(out_data), 512'(0));
        rst = 1'b0;

        // Full-throughput stream of (r,c) = 16r + c
        load_tile(0);
        push_snapshot();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].cap, vecs[i].rdy);
            checkOutput($sformatf("t1_valid_%0d", i), out_valid, vecs[i].valid);
            checkVec($sformatf("t1_row_%0d", i), 512'(out_row), 512'(vecs[i].row));
            checkOutput($sformatf("t1_last_%0d", i), out_last, vecs[i].last);
            checkOutput($sformatf("t1_clr_%0d", i), acc_clr, vecs[i].clr);
            checkOutput($sformatf("t1_done_%0d", i), done, vecs[i].done);
            checkOutput($sformatf("t1_busy_%0d", i), busy, vecs[i].busy);
            if (i == 2) checkVec("t1_row2_data", 512'(out_data), 512'(ROW2));
        end
        checkVec("t1_sb_empty", 512'(sb.size()), 512'(0));

        // Backpressure on row 1
        load_tile(100);
        push_snapshot();
        beats = 0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        held_data = out_data;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkVec($sformatf("t2_stall_row_%0d", i), 512'(out_row), 512'(1));
            checkVec($sformatf("t2_stall_data_%0d", i), 512'(out_data), 512'(held_data));
            checkOutput($sformatf("t2_stall_valid_%0d", i), out_valid, 1'b1);
        end
        drain_until_done(10, "t2_done");
        checkVec("t2_beats", 512'(beats), 512'(4));
        checkOutput("t2_no_overrun", overrun, 1'b0);

        // Capture while streaming row 2 is ignored and flags overrun
        load_tile(300);
        push_snapshot();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        load_tile(900);
        applyStimulus(1'b1, 1'b1);
        checkOutput("t3_overrun", overrun, 1'b1);
        checkOutput("t3_no_clr", acc_clr, 1'b0);
        checkVec("t3_row", 512'(out_row), 512'(3));
        drain_until_done(10, "t3_done");
        checkOutput("t3_overrun_sticky", overrun, 1'b1);

        // Reset during row 1
        load_tile(400);
        push_snapshot();
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b1);
        rst = 1'b0;
        sb.delete();
        checkOutput("t4_valid", out_valid, 1'b0);
        checkOutput("t4_busy", busy, 1'b0);
        checkOutput("t4_overrun_cleared", overrun, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1);
            checkOutput($sformatf("t4_no_done_%0d", i), done, 1'b0);
            checkOutput($sformatf("t4_no_clr_%0d", i), acc_clr, 1'b0);
        end
        load_tile(500);
        push_snapshot();
        applyStimulus(1'b1, 1'b1);
        checkVec("t4_restart_row", 512'(out_row), 512'(0));
        checkOutput("t4_restart_clr", acc_clr, 1'b1);
        drain_until_done(10, "t4_done");

        // Back-to-back capture in the done cycle
        load_tile(600);
        push_snapshot();
        applyStimulus(1'b1, 1'b1);
        checkOutput("t6_clr_first", acc_clr, 1'b1);
        repeat (3) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_done", done, 1'b1);
        checkOutput("t6_idle", out_valid, 1'b0);
        load_tile(700);
        push_snapshot();
        applyStimulus(1'b1, 1'b1);
        checkOutput("t6_valid", out_valid, 1'b1);
        checkVec("t6_row", 512'(out_row), 512'(0));
        checkOutput("t6_clr_second", acc_clr, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("t6_clr_once", acc_clr, 1'b0);
        drain_until_done(10, "t6_done2");

`ifdef RESULT_REQUANT_EN
        // Requantization with shift = 4
        cur_shift = 4;
        acc_in_flat = '0;
        acc_in_flat[0*AW +: AW] = 32'h0000_0FF0;
        acc_in_flat[1*AW +: AW] = 32'hFFFF_FF00;
        acc_in_flat[2*AW +: AW] = 32'h0000_0070;
        acc_in_flat[3*AW +: AW] = 32'h8000_0000;
        push_snapshot();
        applyStimulus(1'b1, 1'b1);
        checkVec("t5_requant_row0", 512'(out_data), 512'(REQ_ROW0));
        drain_until_done(10, "t5_done");
        cur_shift = 0;
`endif

        applyStimulus(1'b0, 1'b0);
        checkVec("final_sb_empty", 512'(sb.size()), 512'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
